// File: rtl/cbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_pkg
//  Description : Shared types and constants for the CBUS fan-out stage.
//                This file holds the transaction FSM state encoding, the
//                read/write encoding of the rw strobe, the default error
//                read value, and a helper that sizes port-index fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package cbus_pkg;

    // Transaction controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_DONE   = 2'd3
    } cbus_state_e;

    // Encoding of the rw strobe
    localparam logic CBUS_RW_WRITE = 1'b1;
    localparam logic CBUS_RW_READ  = 1'b0;

    // Read value returned with an error response
    localparam logic [31:0] CBUS_ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Width of the slave ack timer and of the timeout counter
    localparam int unsigned CBUS_TIMER_W = 16;
    localparam int unsigned CBUS_TCNT_W  = 8;

    // Width of a port index. A single port still gets one bit so that the
    // index signal always exists.
    function automatic int unsigned cbus_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_addr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_addr_dec
//  Description : Combinational CBUS address decoder. It splits a master
//                address into a slave port index and a local offset within
//                that port's block.
//                Ports:
//                  i_addr  - master address
//                  o_port  - selected port index (valid when o_hit)
//                  o_local - offset within the block, zero-extended
//                  o_hit   - address falls in a mapped port block
//  Revision    : 1.0 - initial release
// ============================================================================
module cbus_addr_dec
    import cbus_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 20,
    parameter int unsigned          PORT_NUM  = 8,
    parameter int unsigned          BLOCK_AW  = 10,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    localparam int unsigned         PORT_W    = cbus_idx_w(PORT_NUM)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [PORT_W-1:0] o_port,
    output logic [ADDR_W-1:0] o_local,
    output logic              o_hit
);

    localparam int unsigned BLK_W = ADDR_W - BLOCK_AW;

    logic [ADDR_W-1:0] w_off;
    logic [BLK_W-1:0]  w_blk;
    logic              w_above_base;
    logic              w_port_ok;

    // The subtraction may wrap for addresses below the base; the separate
    // unsigned compare rejects those, so the wrapped offset is never used.
    assign w_off        = i_addr - BASE_ADDR;
    assign w_blk        = w_off[ADDR_W-1:BLOCK_AW];
    assign w_above_base = (i_addr >= BASE_ADDR);
    // Compare the full block number, not the truncated index, so blocks
    // beyond the last port alias nowhere.
    assign w_port_ok    = (64'(w_blk) < 64'(PORT_NUM));

    assign o_hit   = w_above_base && w_port_ok;
    assign o_port  = w_blk[PORT_W-1:0];
    assign o_local = {{BLK_W{1'b0}}, w_off[BLOCK_AW-1:0]};

endmodule
`default_nettype wire

// File: rtl/cbus_dec_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_dec_fsm
//  Description : CBUS address decoder and single-outstanding transaction
//                controller. A master request is decoded to one slave port.
//                It is issued as a one-hot sub-request and completed by the
//                slave ack, by a timeout, or at once as an error when the
//                address is unmapped.
//                Ports:
//                  i_clk_sys, i_rst_sys_n   - clock, async active-low reset
//                  i_cbus_req/rw/addr/wdata - master request (held until ack)
//                  o_cbus_ack/err/rdata     - master response (ack = 1 pulse)
//                  o_cbus_sub_req/rw        - per-port request / rw copy
//                  o_cbus_sub_addr/wdata    - per-port local addr / wdata
//                  i_cbus_sub_ack/rdata     - per-port ack pulse / read data
//                  o_timeout_cnt            - saturating timeout counter
//  Revision    : 1.0 - initial release
// ============================================================================
module cbus_dec_fsm
    import cbus_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 20,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          PORT_NUM    = 8,
    parameter int unsigned          BLOCK_AW    = 10,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0]    ERR_RDATA   = DATA_W'(CBUS_ERR_RDATA_DEF)
) (
    input  logic                        i_clk_sys,
    input  logic                        i_rst_sys_n,
    input  logic                        i_cbus_req,
    input  logic                        i_cbus_rw,
    input  logic [ADDR_W-1:0]           i_cbus_addr,
    input  logic [DATA_W-1:0]           i_cbus_wdata,
    output logic                        o_cbus_ack,
    output logic                        o_cbus_err,
    output logic [DATA_W-1:0]           o_cbus_rdata,
    output logic [PORT_NUM-1:0]         o_cbus_sub_req,
    output logic [PORT_NUM-1:0]         o_cbus_sub_rw,
    output logic [PORT_NUM*ADDR_W-1:0]  o_cbus_sub_addr,
    output logic [PORT_NUM*DATA_W-1:0]  o_cbus_sub_wdata,
    input  logic [PORT_NUM-1:0]         i_cbus_sub_ack,
    input  logic [PORT_NUM*DATA_W-1:0]  i_cbus_sub_rdata,
    output logic [CBUS_TCNT_W-1:0]      o_timeout_cnt
);

    localparam int unsigned               PORT_W    = cbus_idx_w(PORT_NUM);
    localparam logic [CBUS_TIMER_W-1:0]   C_TIMEOUT = CBUS_TIMER_W'(TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [PORT_W-1:0] w_dec_port;
    logic [ADDR_W-1:0] w_dec_local;
    logic              w_dec_hit;

    cbus_addr_dec #(
        .ADDR_W    (ADDR_W),
        .PORT_NUM  (PORT_NUM),
        .BLOCK_AW  (BLOCK_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_dec (
        .i_addr  (i_cbus_addr),
        .o_port  (w_dec_port),
        .o_local (w_dec_local),
        .o_hit   (w_dec_hit)
    );

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    cbus_state_e                 state_q;
    logic                        rw_q;
    logic [PORT_W-1:0]           port_q;
    logic [CBUS_TIMER_W-1:0]     timer_q;
    logic                        ack_q;
    logic                        err_q;
    logic [DATA_W-1:0]           rdata_q;
    logic [PORT_NUM-1:0]         sub_req_q;
    logic [PORT_NUM-1:0]         sub_rw_q;
    logic [PORT_NUM*ADDR_W-1:0]  sub_addr_q;
    logic [PORT_NUM*DATA_W-1:0]  sub_wdata_q;
    logic [CBUS_TCNT_W-1:0]      tcnt_q;

    always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
        if (!i_rst_sys_n) begin
            state_q     <= ST_IDLE;
            rw_q        <= CBUS_RW_READ;
            port_q      <= '0;
            timer_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            sub_req_q   <= '0;
            sub_rw_q    <= '0;
            sub_addr_q  <= '0;
            sub_wdata_q <= '0;
            tcnt_q      <= '0;
        end else begin
            // The master ack is a single-cycle pulse; it is only set on
            // the transition into RESP.
            ack_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_cbus_req) begin
                        rw_q   <= i_cbus_rw;
                        port_q <= w_dec_port;
                        if (w_dec_hit) begin
                            sub_req_q                               <= '0;
                            sub_req_q[w_dec_port]                   <= 1'b1;
                            sub_rw_q[w_dec_port]                    <= i_cbus_rw;
                            sub_addr_q[w_dec_port*ADDR_W +: ADDR_W] <= w_dec_local;
                            sub_wdata_q[w_dec_port*DATA_W +: DATA_W] <= i_cbus_wdata;
                            timer_q                                 <= '0;
                            state_q                                 <= ST_ACCESS;
                        end else begin
                            // Unmapped: answer directly, no slave is touched
                            err_q   <= 1'b1;
                            rdata_q <= ERR_RDATA;
                            ack_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    end
                end

                ST_ACCESS: begin
                    // Slave ack is checked first so it wins over a timeout
                    // expiring in the same cycle.
                    if (i_cbus_sub_ack[port_q]) begin
                        sub_req_q <= '0;
                        err_q     <= 1'b0;
                        if (rw_q == CBUS_RW_READ) begin
                            rdata_q <= i_cbus_sub_rdata[port_q*DATA_W +: DATA_W];
                        end
                        ack_q     <= 1'b1;
                        state_q   <= ST_RESP;
                    end else if (timer_q == C_TIMEOUT) begin
                        sub_req_q <= '0;
                        err_q     <= 1'b1;
                        rdata_q   <= ERR_RDATA;
                        if (tcnt_q != {CBUS_TCNT_W{1'b1}}) begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                        ack_q     <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    // err accompanies the ack pulse only
                    err_q   <= 1'b0;
                    state_q <= ST_DONE;
                end

                ST_DONE: begin
                    // Wait for the master to release a held request so it
                    // is not issued a second time.
                    if (!i_cbus_req) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cbus_ack       = ack_q;
    assign o_cbus_err       = err_q;
    assign o_cbus_rdata     = rdata_q;
    assign o_cbus_sub_req   = sub_req_q;
    assign o_cbus_sub_rw    = sub_rw_q;
    assign o_cbus_sub_addr  = sub_addr_q;
    assign o_cbus_sub_wdata = sub_wdata_q;
    assign o_timeout_cnt    = tcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cbus_dec_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cbus_dec_fsm
//  Description : Self-checking bench for cbus_dec_fsm with default
//                parameters. Directed transactions push their expected
//                response into a queue; a monitor pops and compares on
//                every master ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cbus_dec_fsm;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int PN = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              rw = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     wdata = '0;
    logic              ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic [PN-1:0]     sub_req;
    logic [PN-1:0]     sub_rw;
    logic [PN*AW-1:0]  sub_addr;
    logic [PN*DW-1:0]  sub_wdata;
    logic [PN-1:0]     sub_ack = '0;
    logic [PN*DW-1:0]  sub_rdata = '0;
    logic [7:0]        tcnt;

    cbus_dec_fsm dut (
        .i_clk_sys        (clk),
        .i_rst_sys_n      (rst_n),
        .i_cbus_req       (req),
        .i_cbus_rw        (rw),
        .i_cbus_addr      (addr),
        .i_cbus_wdata     (wdata),
        .o_cbus_ack       (ack),
        .o_cbus_err       (err),
        .o_cbus_rdata     (rdata),
        .o_cbus_sub_req   (sub_req),
        .o_cbus_sub_rw    (sub_rw),
        .o_cbus_sub_addr  (sub_addr),
        .o_cbus_sub_wdata (sub_wdata),
        .i_cbus_sub_ack   (sub_ack),
        .i_cbus_sub_rdata (sub_rdata),
        .o_timeout_cnt    (tcnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          err;
        logic [DW-1:0] rd;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: ack at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("resp_err",   32'(err), 32'(e.err));
                check("resp_rdata", rdata,    e.rd);
                check("resp_cycle", cyc,      e.cyc);
            end
        end
    end

    // One master transaction with a scripted slave. Cycle 0 is the cycle
    // req is first high; port < 0 means the address is unmapped.
    task automatic txn(input string nm, input logic t_rw, input logic [AW-1:0] t_addr,
                       input logic [DW-1:0] t_wdata, input int port, input logic [AW-1:0] lad,
                       input int ack_j, input logic [DW-1:0] srd, input int stray_j,
                       input int late_j, input int hold, input logic e_err,
                       input logic [DW-1:0] e_rd, input int e_lat, input int e_reqcyc);
        exp_t e;
        int   ja;
        int   end_j;
        int   reqcyc;
        @(posedge clk); #1;
        req   = 1'b1;
        rw    = t_rw;
        addr  = t_addr;
        wdata = t_wdata;
        e.err = e_err;
        e.rd  = e_rd;
        e.cyc = cyc + e_lat;
        exp_q.push_back(e);
        ja     = -1;
        end_j  = 400;
        reqcyc = 0;
        for (int j = 1; j <= end_j; j++) begin
            @(posedge clk); #1;
            sub_ack   = '0;
            sub_rdata = '0;
            if (port >= 0) begin
                sub_rdata[port*DW +: DW] = srd;
                if (j == ack_j || j == late_j) sub_ack[port] = 1'b1;
                if (j == stray_j) sub_ack[(port+1)%PN] = 1'b1;
            end
            if (j == 1) begin
                if (port >= 0) begin
                    check({nm, "_subreq"},  32'(sub_req), 32'(1) << port);
                    check({nm, "_subrw"},   32'(sub_rw[port]), 32'(t_rw));
                    check({nm, "_subaddr"}, 32'(sub_addr[port*AW +: AW]), 32'(lad));
                    if (t_rw) check({nm, "_subwdata"}, sub_wdata[port*DW +: DW], t_wdata);
                end else begin
                    check({nm, "_subreq_none"}, 32'(sub_req), 32'h0);
                end
            end
            if (sub_req != '0) reqcyc++;
            if (ack && ja < 0) begin
                ja    = j;
                end_j = j + hold + 2;
            end
            if (ja >= 0 && j == ja + hold) req = 1'b0;
        end
        sub_ack = '0;
        req     = 1'b0;
        if (ja < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ack_wait: no ack within 400 cycles, required ack at cycle %0d", nm, e_lat);
        end
        check({nm, "_subreq_cycles"}, reqcyc, e_reqcyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",     32'(ack),     32'h0);
        check("rst_err",     32'(err),     32'h0);
        check("rst_rdata",   rdata,        32'h0);
        check("rst_subreq",  32'(sub_req), 32'h0);
        check("rst_subaddr", 32'(sub_addr[2*AW +: AW]), 32'h0);
        check("rst_tcnt",    32'(tcnt),    32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //   name   rw    addr       wdata          port lad     ackj srd            stray late hold err  exp_rd         lat  reqcyc
        txn("rd_p2", 1'b0, 20'h00804, 32'h0,         2,   20'h004, 4, 32'h1234_5678, 2,    0,   0,   1'b0, 32'h1234_5678, 5,   4);
        txn("wr_p7", 1'b1, 20'h01FFC, 32'hA5A5_A5A5, 7,   20'h3FC, 1, 32'hFFFF_0000, 0,    0,   5,   1'b0, 32'h1234_5678, 2,   1);
        txn("rd_um", 1'b0, 20'h02000, 32'h0,         -1,  20'h000, 0, 32'h0,         0,    0,   0,   1'b1, 32'hDEAD_BEEF, 1,   0);
        txn("rd_to", 1'b0, 20'h00C10, 32'h0,         3,   20'h010, 0, 32'h5555_AAAA, 0,    258, 2,   1'b1, 32'hDEAD_BEEF, 257, 256);
        check("tcnt_after_timeout", 32'(tcnt), 32'h1);
        txn("rd_tie", 1'b0, 20'h00C20, 32'h0,        3,   20'h020, 256, 32'h0BAD_F00D, 0,  0,   1,   1'b0, 32'h0BAD_F00D, 257, 256);
        check("tcnt_after_tie", 32'(tcnt), 32'h1);
        txn("wr_um", 1'b1, 20'hFFFFF, 32'h1111_2222, -1,  20'h000, 0, 32'h0,         0,    0,   1,   1'b1, 32'hDEAD_BEEF, 1,   0);
        txn("wr_p0", 1'b1, 20'h003FF, 32'h7777_8888, 0,   20'h3FF, 2, 32'h9999_9999, 0,    0,   0,   1'b0, 32'hDEAD_BEEF, 3,   2);

        // Reset while a slave access is outstanding
        @(posedge clk); #1;
        req  = 1'b1;
        rw   = 1'b0;
        addr = 20'h00804;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_subreq", 32'(sub_req), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_subreq", 32'(sub_req), 32'h0);
        check("mid_rst_ack",    32'(ack),     32'h0);
        check("mid_rst_rdata",  rdata,        32'h0);
        check("mid_rst_tcnt",   32'(tcnt),    32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        txn("rd_p2_again", 1'b0, 20'h00804, 32'h0, 2, 20'h004, 4, 32'h1234_5678, 0, 0, 0, 1'b0, 32'h1234_5678, 5, 4);

        repeat (3) @(posedge clk);
        #1;
        check("pending_resp", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
